// File: rtl/seg8_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg8_scan_driver_if
// Brief    : Display values in, scanned segment/anode drive and frame strobe out.
// Revision : 1.0 - initial release
// ============================================================================
interface seg8_scan_driver_if;
    logic [2:0] sp;
    logic [2:0] fr;
    logic [7:0] os;
    logic [2:0] po;
    logic [7:0] oa;
    logic       oc;

    modport master (
        output sp,
        output fr,
        input  os,
        input  po,
        input  oa,
        input  oc
    );

    modport slave (
        input  sp,
        input  fr,
        output os,
        output po,
        output oa,
        output oc
    );
endinterface
`default_nettype wire

// File: rtl/seg8_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg8_scan_driver
// Brief    : 8-digit common-anode 7-segment scanner showing fr on digit 0 and
//            sp on digit 1, with a one-clock strobe on each frame wrap.
// Revision : 1.0 - initial release
// ============================================================================
module seg8_scan_driver #(
    parameter int SCAN_DIV = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seg8_scan_driver_if.slave  bus
);

    localparam int                  c_CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]          c_BLANK    = 8'hFF;

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_po;
    logic [7:0]         r_oa;
    logic [7:0]         r_os;
    logic               r_oc;

    logic               w_step;
    logic [2:0]         w_po_next;
    logic [7:0]         w_os_next;
    logic [7:0]         w_oa_next;

    // Active-low segments g..a with the decimal point held off.
    function automatic logic [7:0] f_numeral(input logic [2:0] v);
        logic [7:0] seg;
        case (v)
            3'd0:    seg = 8'hC0;
            3'd1:    seg = 8'hF9;
            3'd2:    seg = 8'hA4;
            3'd3:    seg = 8'hB0;
            3'd4:    seg = 8'h99;
            3'd5:    seg = 8'h92;
            3'd6:    seg = 8'h82;
            default: seg = 8'hF8;
        endcase
        return seg;
    endfunction

    assign w_step    = (r_cnt == c_CNT_LAST);
    assign w_po_next = r_po + 3'd1;
    assign w_oa_next = ~(8'b1 << w_po_next);

    // Content is chosen for the digit about to be lit, so inputs are sampled
    // only on the step edge and never disturb a slot in progress.
    always_comb begin
        w_os_next = c_BLANK;
        case (w_po_next)
            3'd0:    w_os_next = f_numeral(bus.fr);
            3'd1:    w_os_next = f_numeral(bus.sp);
            default: w_os_next = c_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_po  <= 3'd0;
            r_oa  <= 8'hFF;
            r_os  <= c_BLANK;
            r_oc  <= 1'b0;
        end else begin
            r_oc <= 1'b0;
            if (w_step) begin
                r_cnt <= '0;
                r_po  <= w_po_next;
                r_oa  <= w_oa_next;
                r_os  <= w_os_next;
                r_oc  <= (w_po_next == 3'd0);
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus.po = r_po;
    assign bus.oa = r_oa;
    assign bus.os = r_os;
    assign bus.oc = r_oc;

endmodule
`default_nettype wire

// File: tb/tb_seg8_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg8_scan_driver
// Brief    : Randomised scoreboard bench for seg8_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg8_scan_driver;

    localparam int c_SD = 4;

    typedef struct {
        logic [2:0] po;
        logic [7:0] oa;
        logic [7:0] os;
        logic       oc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    seg8_scan_driver_if bus ();

    seg8_scan_driver #(.SCAN_DIV(c_SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [7:0] num [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position derived purely from elapsed edges since release.
    int edges;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            q.delete();
        end else begin
            edges++;
            if (edges % c_SD == 0) begin
                exp_t e;
                int   pos;
                pos  = (edges / c_SD) % 8;
                e.po = 3'(pos);
                e.oa = 8'hFF;
                e.oa[pos] = 1'b0;
                e.os = (pos == 0) ? num[bus.fr] : (pos == 1) ? num[bus.sp] : 8'hFF;
                e.oc = (pos == 0);
                q.push_back(e);
            end
        end
    end

    // Monitor: a step is presented whenever the lit digit changes.
    logic [2:0] prev_po;
    logic [7:0] prev_oa;
    int         slot;
    bit         seen_step;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {13'd0, bus.os, bus.oa, bus.po, bus.oc}, {13'd0, 8'hFF, 8'hFF, 3'd0, 1'b0});
            prev_po   = 3'd0;
            prev_oa   = 8'hFF;
            slot      = 0;
            seen_step = 0;
        end else begin
            slot++;
            if (bus.po !== prev_po || bus.oa !== prev_oa) begin
                if (q.size() == 0) begin
                    chk("unexpected_step", {29'd0, bus.po}, {29'd0, prev_po});
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("step_po", {29'd0, bus.po}, {29'd0, e.po});
                    chk("step_oa", {24'd0, bus.oa}, {24'd0, e.oa});
                    chk("step_os", {24'd0, bus.os}, {24'd0, e.os});
                    chk("step_oc", {31'd0, bus.oc}, {31'd0, e.oc});
                end
                if (seen_step) chk("slot_len", slot, c_SD);
                chk("oa_onehot", $countones(~bus.oa), 1);
                seen_step = 1;
                slot      = 0;
                prev_po   = bus.po;
                prev_oa   = bus.oa;
            end else begin
                chk("oc_idle", {31'd0, bus.oc}, 32'd0);
                if (q.size() != 0) begin
                    chk("missed_step", q.size(), 0);
                    q.delete();
                end
            end
        end
    end

    task automatic run_random(input int cycles, input int chance);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(chance - 1) == 0) begin
                bus.sp = 3'($urandom_range(7));
                bus.fr = 3'($urandom_range(7));
            end
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        repeat (25) @(negedge clk);

        bus.sp = 3'd3;
        bus.fr = 3'd2;
        rst_n  = 1'b1;
        repeat (8 * c_SD + 2) @(negedge clk);

        bus.sp = 3'd7;
        bus.fr = 3'd0;
        run_random(225 - (8 * c_SD + 2), 1000000);
        run_random(400, 11);

        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.po == 3'd5) found = 1;
        end
        chk("wait_po5", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {13'd0, bus.os, bus.oa, bus.po, bus.oc}, {13'd0, 8'hFF, 8'hFF, 3'd0, 1'b0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_random(300, 7);

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg8_scan_driver.md
Name:
seg8_scan_driver

Overview:
- Time-multiplexed driver for an 8-digit, common-anode 7-segment display in the piano design.
- Shows the current note/frequency index `fr` on digit 0 and the speed level `sp` on digit 1; digits 2-7 are blank.
- Scans one digit at a time.
- Also emits a one-cycle frame strobe each time the scan wraps back to digit 0.

Parameters:
- SCAN_DIV, default 4: clock cycles per digit slot. Must be >= 2. Board builds override it, e.g. 100000 for ~1 kHz digit rate at 100 MHz.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- sp  input  3  speed level 0-7, shown on digit 1
- fr  input  3  note/frequency index 0-7, shown on digit 0
- os  output  8  segment pattern, active-low; os[7]=dp, os[6:0]=g,f,e,d,c,b,a
- po  output  3  index of the currently lit digit, 0-7
- oa  output  8  anode select, active-low one-hot; oa[i]=0 when digit i is lit
- oc  output  1  frame strobe; high for exactly one clock when po wraps 7->0

Behaviour:
- Reset (rst_n=0, asynchronous, held while low):
  - po=0, oa=8'hFF (all digits off), os=8'hFF (all segments off), oc=0.
  - Divider counter = 0.
- Divider:
  - Counter counts 0..SCAN_DIV-1, advancing by 1 each clock.
  - When the counter equals SCAN_DIV-1, a digit step occurs and the counter returns to 0.
- Digit step (all outputs registered, updated on the same edge):
  - po <= po+1, wrapping mod 8 (7 -> 0).
  - oa <= ~(8'b1 << new po).
  - os <= pattern for new po, built from sp/fr sampled on that edge.
- Strobe:
  - oc=1 on the cycle following a step whose new po is 0; oc=0 otherwise.
  - Width is exactly one clock, independent of SCAN_DIV.
- First step:
  - Occurs on the SCAN_DIV-th rising edge after rst_n deasserts; po becomes 1.
  - Until then outputs hold their reset values.
- Digit content:
  - po=0: numeral of fr.
  - po=1: numeral of sp.
  - po=2..7: blank, 8'hFF.
  - Decimal point is always off (os[7]=1).
- Numeral encoding, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
- Input changes:
  - sp/fr are not registered between steps.
  - A change is visible at the next step that lands on its digit; no glitch occurs mid-slot.
- Reset mid-scan:
  - Immediately returns all outputs and the divider to their reset values.
  - Scanning restarts from the beginning after release.
- Digit period is SCAN_DIV clocks; frame period is 8*SCAN_DIV clocks.
- Exactly one oa bit is low at any time after the first step.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 25 cycles, inputs undriven.
  - Required: os=FF, oa=FF, po=0, oc=0 throughout.
- First step (SCAN_DIV=4):
  - Stimulus: release reset with sp=3, fr=2.
  - Required: on the 4th edge after release, po=1, oa=FD, os=B0.
  - Required: os/oa are stable for exactly 4 cycles.
- Blank digits:
  - Stimulus: continue scanning.
  - Required: steps to po=2..7 give oa=FB, F7, EF, DF, BF, 7F, each with os=FF.
- Wrap:
  - Stimulus: continue scanning.
  - Required: the 8th step gives po=0, oa=FE, os=A4.
  - Required: oc=1 for one cycle at that step; no other oc pulses over a 225-cycle run.
- Input change:
  - Stimulus: set sp=7, fr=0 mid-frame.
  - Required: next po=1 slot shows os=F8; next po=0 slot shows os=C0.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 while po=5.
  - Required: outputs return to FF/FF/0/0 without waiting for a clock edge.
  - Required: after release, the first step again lands on po=1 after SCAN_DIV edges.
